// File: rtl/input_debouncer.sv
// input_debouncer: synchronise, debounce and polarity-normalise raw board inputs, with press/release pulses
module input_debouncer #(
  parameter int NUM_INPUTS      = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] raw_in,
  output logic [NUM_INPUTS-1:0] data_out,
  output logic [NUM_INPUTS-1:0] press_pulse,
  output logic [NUM_INPUTS-1:0] rel_pulse,
  output logic                  any_event
);
  localparam logic [NUM_INPUTS-1:0] IDLE = ACTIVE_LOW ? '1 : '0;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [NUM_INPUTS-1:0] meta_q, sync_q, stable_q, stable_d;
  logic [NUM_INPUTS-1:0] data_q, data_d, press_q, press_d, rel_q, rel_d;
  logic                  any_q, any_d;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 differ, done;
    // any matching cycle, or a commit, restarts the count from zero
    assign differ      = sync_q[i] != stable_q[i];
    assign done        = differ && cnt_q == LAST;
    assign cnt_d       = differ && !done ? cnt_q + CNT_WIDTH'(1) : '0;
    assign stable_d[i] = done ? sync_q[i] : stable_q[i];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end
  always_comb begin
    data_d  = stable_q ^ IDLE;
    press_d = data_d & ~data_q;
    rel_d   = ~data_d & data_q;
    any_d   = |(press_d | rel_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= IDLE;
      sync_q   <= IDLE;
      stable_q <= IDLE;
      data_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      any_q    <= 1'b0;
    end else begin
      meta_q   <= raw_in;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      data_q   <= data_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      any_q    <= any_d;
    end
  end
  assign data_out    = data_q;
  assign press_pulse = press_q;
  assign rel_pulse   = rel_q;
  assign any_event   = any_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench for input_debouncer (DC=4 active-low, DC=4 active-high, DC=1 active-low)
module tb_input_debouncer;
  localparam int N = 12;
  typedef struct {
    int           due;
    logic [N-1:0] data;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] raw_a, raw_b, raw_c;
  logic [N-1:0] data_a, press_a, rel_a, data_b, press_b, rel_b, data_c, press_c, rel_c;
  logic         any_a, any_b, any_c;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  input_debouncer #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_a), .data_out(data_a),
    .press_pulse(press_a), .rel_pulse(rel_a), .any_event(any_a));
  input_debouncer #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_b), .data_out(data_b),
    .press_pulse(press_b), .rel_pulse(rel_b), .any_event(any_b));
  input_debouncer #(.NUM_INPUTS(N), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(1), .ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_c), .data_out(data_c),
    .press_pulse(press_c), .rel_pulse(rel_c), .any_event(any_c));

  task automatic push_exp(input int lat, input logic [N-1:0] d, input logic [N-1:0] p, input logic [N-1:0] r);
    exp_t e;
    e = '{due: cyc + 1 + lat, data: d, press: p, rel: r};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    raw_a = '1;
    raw_b = '0;
    raw_c = '1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_a, press_a, rel_a, any_a, data_b, press_b, rel_b, any_b, data_c, press_c, rel_c, any_c} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs a=%h/%h/%h/%b b=%h c=%h, required all zero", data_a, press_a, rel_a, any_a, data_b, data_c);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({data_a, press_a, rel_a, any_a, data_b, press_b, rel_b, any_b, data_c, press_c, rel_c, any_c} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: a=%h/%h/%h/%b b=%h/%b c=%h/%b, required all zero", i, data_a, press_a, rel_a, any_a, data_b, any_b, data_c, any_c);
      end
    end
  endtask

  task automatic drain_note(input string name);
    exp_t e;
    bit   hit;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin @(negedge clk); hit = any_a; end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL %s timeout: any_event never rose, required at cycle %0d", name, e.due);
      end else begin
        checks++;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL %s latency: event at cycle %0d, required cycle %0d", name, cyc, e.due);
        end
        checks++;
        if ({data_a, press_a, rel_a} !== {e.data, e.press, e.rel}) begin
          errors++;
          $display("FAIL %s outputs: data=%h press=%h rel=%h, required %h %h %h", name, data_a, press_a, rel_a, e.data, e.press, e.rel);
        end
        @(negedge clk);
        checks++;
        if ({press_a, rel_a, any_a} !== '0 || data_a !== e.data) begin
          errors++;
          $display("FAIL %s width: press=%h rel=%h any=%b data=%h, required 0 0 0 %h", name, press_a, rel_a, any_a, data_a, e.data);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    @(negedge clk);
    raw_a[0] = 1'b0;
    push_exp(6, 12'h001, 12'h001, 12'h000);
    drain_note("clean_press");
  endtask

  task automatic test_bounce();
    @(negedge clk);
    raw_a[3] = 1'b0;
    repeat (3) @(negedge clk);
    raw_a[3] = 1'b1;
    @(negedge clk);
    raw_a[3] = 1'b0;
    push_exp(6, 12'h009, 12'h008, 12'h000);
    drain_note("bounce");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    raw_a[5]  = 1'b0;
    raw_a[11] = 1'b0;
    push_exp(6, 12'h829, 12'h820, 12'h000);
    drain_note("multi_press");
    @(negedge clk);
    raw_a[0]  = 1'b1;
    raw_a[5]  = 1'b1;
    raw_a[11] = 1'b1;
    push_exp(6, 12'h008, 12'h000, 12'h821);
    drain_note("multi_release");
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    raw_a[3] = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({data_a, press_a, rel_a, any_a} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: data=%h press=%h rel=%h any=%b, required all zero", data_a, press_a, rel_a, any_a);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= any_a | (|data_a); end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_quiet: activity after reset, required none (data=%h)", data_a);
    end
    raw_a[2] = 1'b0;
    repeat (3) @(negedge clk);
    raw_a[2] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); seen |= any_a | (|data_a); end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL short_hold: event after 3-cycle hold, required none (data=%h)", data_a);
    end
    raw_a[2] = 1'b0;
    push_exp(6, 12'h004, 12'h004, 12'h000);
    drain_note("post_reset_press");
  endtask

  task automatic test_active_high();
    exp_t e;
    bit   hit;
    @(negedge clk);
    raw_b[7] = 1'b1;
    push_exp(6, 12'h080, 12'h080, 12'h000);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        @(negedge clk);
        raw_b[7] = 1'b0;
        push_exp(6, 12'h000, 12'h000, 12'h080);
      end
      e = sb.pop_front();
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin @(negedge clk); hit = any_b; end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL active_high_%0d timeout: no event, required at cycle %0d", k, e.due);
      end else begin
        checks++;
        if (cyc !== e.due || {data_b, press_b, rel_b} !== {e.data, e.press, e.rel}) begin
          errors++;
          $display("FAIL active_high_%0d: cycle %0d data=%h press=%h rel=%h, required cycle %0d %h %h %h",
                   k, cyc, data_b, press_b, rel_b, e.due, e.data, e.press, e.rel);
        end
      end
    end
  endtask

  task automatic test_dc1();
    exp_t e;
    bit   hit;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      raw_c[4] = k == 1;
      push_exp(3, k == 0 ? 12'h010 : 12'h000, k == 0 ? 12'h010 : 12'h000, k == 1 ? 12'h010 : 12'h000);
      e = sb.pop_front();
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin @(negedge clk); hit = any_c; end
      checks++;
      if (!hit) begin
        errors++;
        $display("FAIL dc1_%0d timeout: no event, required at cycle %0d", k, e.due);
      end else begin
        checks++;
        if (cyc !== e.due || {data_c, press_c, rel_c} !== {e.data, e.press, e.rel}) begin
          errors++;
          $display("FAIL dc1_%0d: cycle %0d data=%h press=%h rel=%h, required cycle %0d %h %h %h",
                   k, cyc, data_c, press_c, rel_c, e.due, e.data, e.press, e.rel);
        end
        @(negedge clk);
        checks++;
        if ({press_c, rel_c, any_c} !== '0) begin
          errors++;
          $display("FAIL dc1_%0d width: press=%h rel=%h any=%b, required zero", k, press_c, rel_c, any_c);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_active_high();
    test_dc1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
